pwm_capture: RTL and testbench

//  Receive-side companion of the PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture_pkg.sv | 19 +
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/pwm_capture.sv | 121 ++++++++++++
 tb/tb_pwm_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: default sizing and FSM state encodings.
`timescale 1ns/100ps
package pwm_capture_pkg;

    // Generator counter width; the capture side uses one extra bit so a full period fits.
    localparam int unsigned WIDTH_DEF       = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef logic [0:0] state_t;

    localparam state_t IDLE    = 1'b0;
    localparam state_t MEASURE = 1'b1;

    // Result/counter width derived from the generator width.
    function automatic int unsigned cw_of(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser for the asynchronous PWM input plus a single-cycle rising-edge detector.
`timescale 1ns/100ps
module pwm_edge_sync
    import pwm_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
)(
    input  logic CLoK,
    input  logic Reset,
    input  logic d_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw input through the synchroniser chain and keep one cycle of history.
    always_ff @(posedge CLoK or negedge Reset) begin
        if (!Reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform, once per period,
// and flags a stuck input when no rising edge arrives within the counter range.
`timescale 1ns/100ps
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter  int unsigned WIDTH       = WIDTH_DEF,
    parameter  int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int unsigned CW          = cw_of(WIDTH)
)(
    input  logic          CLoK,
    input  logic          Reset,
    input  logic          PWM_IN,
    output logic [CW-1:0] HIGH_CNT,
    output logic [CW-1:0] PERIOD,
    output logic          VALID,
    output logic          TIMEOUT,
    output logic          LEVEL
);

    localparam logic [CW-1:0] MAX = '1;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic w_s;
    logic w_rise;

    state_t        r_state,   w_state_nxt;
    logic [CW-1:0] r_pcnt,    w_pcnt_nxt;
    logic [CW-1:0] r_hcnt,    w_hcnt_nxt;
    logic [CW-1:0] r_high,    w_high_nxt;
    logic [CW-1:0] r_period,  w_period_nxt;
    logic          r_valid,   w_valid_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_level,   w_level_nxt;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .CLoK  (CLoK),
        .Reset (Reset),
        .d_in  (PWM_IN),
        .s     (w_s),
        .rise  (w_rise)
    );

    // Next-state logic: measure between rising edges, time out when the period counter saturates.
    always_comb begin
        w_state_nxt   = r_state;
        w_pcnt_nxt    = r_pcnt;
        w_hcnt_nxt    = r_hcnt;
        w_high_nxt    = r_high;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = r_timeout;
        w_level_nxt   = r_level;

        case (r_state)
            IDLE: begin
                // First rise only starts a measurement; the preceding period is partial.
                if (w_rise) begin
                    w_pcnt_nxt  = ONE;
                    w_hcnt_nxt  = ONE;
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // A rise takes priority over a saturated counter, so a period of exactly MAX is reported.
                if (w_rise) begin
                    w_period_nxt  = r_pcnt;
                    w_high_nxt    = r_hcnt;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_pcnt_nxt    = ONE;
                    w_hcnt_nxt    = ONE;
                end else if (r_pcnt != MAX) begin
                    w_pcnt_nxt = r_pcnt + ONE;
                    if (w_s && (r_hcnt != MAX)) begin
                        w_hcnt_nxt = r_hcnt + ONE;
                    end
                end else begin
                    w_timeout_nxt = 1'b1;
                    w_level_nxt   = w_s;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLoK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_pcnt    <= '0;
            r_hcnt    <= '0;
            r_high    <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_high    <= w_high_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_level   <= w_level_nxt;
        end
    end

    assign HIGH_CNT = r_high;
    assign PERIOD   = r_period;
    assign VALID    = r_valid;
    assign TIMEOUT  = r_timeout;
    assign LEVEL    = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected measurements and
// timeout events derived from the driven waveform; a monitor checks every VALID.
`timescale 1ns/100ps
module tb_pwm_capture;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = WIDTH + 1;
    localparam int          MAXP  = 31;

    logic          CLoK;
    logic          Reset;
    logic          PWM_IN;
    logic [CW-1:0] HIGH_CNT;
    logic [CW-1:0] PERIOD;
    logic          VALID;
    logic          TIMEOUT;
    logic          LEVEL;

    typedef struct {
        int high;
        int period;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         to_q[$];
    exp_t       mon_e;
    int         n_vec     = 0;
    int         n_miss    = 0;
    int         cyc       = 0;
    int         last_rise = 0;
    int         h_acc     = 0;
    bit         have_rise = 1'b0;
    bit         strict    = 1'b0;
    logic [2:0] hist      = 3'b000;

    pwm_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .CLoK     (CLoK),
        .Reset    (Reset),
        .PWM_IN   (PWM_IN),
        .HIGH_CNT (HIGH_CNT),
        .PERIOD   (PERIOD),
        .VALID    (VALID),
        .TIMEOUT  (TIMEOUT),
        .LEVEL    (LEVEL)
    );

    initial begin
        CLoK = 1'b0;
        forever #5 CLoK = ~CLoK;
    end

    always @(posedge CLoK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high"},    int'(HIGH_CNT), 0);
        chk({tag, "_period"},  int'(PERIOD),   0);
        chk({tag, "_valid"},   int'(VALID),    0);
        chk({tag, "_timeout"}, int'(TIMEOUT),  0);
        chk({tag, "_level"},   int'(LEVEL),    0);
    endtask

    // A 0->1 transition on PWM_IN: close the previous period and schedule its timeout.
    task automatic rise_event();
        int p;
        p = cyc - last_rise;
        if (have_rise && (p <= MAXP)) begin
            exp_q.push_back('{h_acc, p, cyc + 3});
            if (to_q.size() > 0) void'(to_q.pop_back());
        end
        to_q.push_back(cyc + 34);
        last_rise = cyc;
        h_acc     = 0;
        have_rise = 1'b1;
    endtask

    // Advance one clock; PWM_IN level during the finished cycle is recorded first.
    task automatic tick();
        if (PWM_IN) h_acc++;
        hist = {hist[1:0], PWM_IN};
        @(posedge CLoK);
        #1;
        while ((to_q.size() > 0) && (to_q[0] == cyc)) begin
            chk("timeout_set",   int'(TIMEOUT), 1);
            chk("timeout_level", int'(LEVEL),   int'(hist[2]));
            void'(to_q.pop_front());
        end
        if (strict && (to_q.size() > 0) && (to_q[0] == cyc + 1))
            chk("timeout_early", int'(TIMEOUT), 0);
    endtask

    task automatic step(input logic lvl);
        if (lvl && !PWM_IN) rise_event();
        PWM_IN = lvl;
        tick();
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic rst_pulse();
        Reset = 1'b0;
        #0.5;
        chk_zero("rst_pulse");
        #0.5;
        Reset     = 1'b1;
        have_rise = 1'b0;
        h_acc     = 0;
        to_q.delete();
    endtask

    task automatic pwm_period(input int p, input int h, input int rst_at);
        for (int i = 0; i < p; i++) begin
            if (i == rst_at) rst_pulse();
            step(i < h);
        end
    endtask

    // Monitor: every VALID must match the oldest queued measurement, in the predicted cycle.
    always @(negedge CLoK) begin
        if (VALID) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL valid_unexpected: got high=%0d period=%0d at cycle %0d, expected no VALID",
                         HIGH_CNT, PERIOD, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ((int'(HIGH_CNT) != mon_e.high) || (int'(PERIOD) != mon_e.period) || (cyc != mon_e.cyc)) begin
                    n_miss++;
                    $display("FAIL valid_result: got high=%0d period=%0d cycle=%0d, expected high=%0d period=%0d cycle=%0d",
                             HIGH_CNT, PERIOD, cyc, mon_e.high, mon_e.period, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        Reset  = 1'b1;
        PWM_IN = 1'b0;
        #1;
        Reset  = 1'b0;

        // Reset held with a toggling input, then an idle low input.
        for (int i = 0; i < 10; i++) begin
            PWM_IN = ~PWM_IN;
            @(posedge CLoK);
            #1;
            if ((i == 3) || (i == 9)) chk_zero("in_reset");
        end
        PWM_IN = 1'b0;
        Reset  = 1'b1;
        hold(1'b0, 40);
        chk("idle_timeout", int'(TIMEOUT),  0);
        chk("idle_high",    int'(HIGH_CNT), 0);
        chk("idle_period",  int'(PERIOD),   0);

        // Steady 16/5 stream.
        for (int i = 0; i < 4; i++) pwm_period(16, 5, -1);

        // Stuck low, stuck high, then recovery.
        strict = 1'b1;
        hold(1'b0, 40);
        strict = 1'b0;
        hold(1'b1, 40);
        hold(1'b0, 3);
        pwm_period(16, 5, -1);
        chk("timeout_sticky", int'(TIMEOUT), 1);
        pwm_period(16, 5, -1);
        chk("timeout_cleared", int'(TIMEOUT), 0);

        // Boundary periods: 31 is measured, 32 times out.
        pwm_period(31, 10, -1);
        pwm_period(31, 10, -1);
        pwm_period(32, 10, -1);
        pwm_period(32, 10, -1);
        pwm_period(31, 10, -1);
        pwm_period(16, 5, -1);

        // Period change at a rise boundary.
        pwm_period(16, 5, -1);
        pwm_period(8, 3, -1);
        pwm_period(8, 3, -1);
        pwm_period(16, 5, -1);

        // Short reset pulse in the low phase of a period.
        pwm_period(16, 5, 8);
        for (int i = 0; i < 3; i++) pwm_period(16, 5, -1);
        hold(1'b0, 40);

        chk("final_high",    int'(HIGH_CNT), 5);
        chk("final_period",  int'(PERIOD),   16);
        chk("final_timeout", int'(TIMEOUT),  1);
        chk("exp_drained",   exp_q.size(),   0);
        chk("to_drained",    to_q.size(),    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
